uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8, SHALL set data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0, SHALL select parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, SHALL set stop bits per frame; legal values 1 or 2.
REQ-005 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 i_reset  input  1  SHALL be the synchronous, active-high reset.
REQ-007 i_wr  input  1  SHALL request transmission of i_data.
REQ-008 i_data  input  DATA_BITS  SHALL carry the word to transmit, sampled only on acceptance.
REQ-009 o_busy  output  1  SHALL be high while a frame is in progress; low means ready.
REQ-010 o_done  output  1  SHALL pulse high for one cycle when a frame's last stop bit completes.
REQ-011 o_state  output  3  SHALL expose the FSM encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4).
REQ-012 o_uart_tx  output  1  SHALL be the serial line; idle/mark level is 1.

Function
REQ-013 Acceptance SHALL occur on a rising edge where i_wr=1 and o_busy=0; i_data is latched into a shift register on that edge.
REQ-014 i_wr while o_busy=1 SHALL be ignored, with no queuing and no effect on the current frame.
REQ-015 After acceptance, o_busy=1 and o_uart_tx=0 (start bit) SHALL take effect on the next cycle, giving one cycle of latency.
REQ-016 Each start, data, parity and stop bit SHALL be held on o_uart_tx for exactly CLKS_PER_BIT cycles.
REQ-017 Bit timing SHALL use a down-counter of width clog2(CLKS_PER_BIT) that reloads CLKS_PER_BIT-1 at each bit boundary; bit advance occurs when it reads 0.
REQ-018 FSM transitions SHALL be:
  - IDLE -> START on acceptance.
  - START -> DATA after one bit time.
  - DATA -> PARITY after DATA_BITS bit times when PARITY!=0, else DATA -> STOP.
  - PARITY -> STOP after one bit time.
  - STOP -> IDLE after STOP_BITS bit times.
REQ-019 Data bits SHALL be sent LSB first by right-shifting the latched word.
REQ-020 The parity bit SHALL be the XOR of the latched data bits: XOR for even parity, inverted XOR for odd parity, computed at acceptance.
REQ-021 Stop bits SHALL drive o_uart_tx=1.
REQ-022 Total frame length SHALL be CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles, and o_busy SHALL be high for exactly that many cycles.
REQ-023 On the cycle the FSM returns to IDLE:
  - o_busy SHALL be 0.
  - o_done SHALL be 1.
  - A new i_wr SHALL be accepted on that same edge, giving back-to-back frames with no idle gap beyond one cycle.
REQ-024 In IDLE, o_uart_tx SHALL be 1 and the bit counter SHALL hold its reload value.
REQ-025 o_uart_tx SHALL be driven directly from a register so that it is glitch-free.

Reset
REQ-026 While i_reset=1, on each rising edge the block SHALL set:
  - o_state=IDLE, o_busy=0, o_done=0, o_uart_tx=1.
  - Counters and shift register cleared.
REQ-027 Reset mid-frame SHALL abort the frame with the line at 1 from the next cycle; no completion pulse is produced.
REQ-028 i_wr asserted together with i_reset SHALL be ignored.
REQ-029 Power-up initial values SHALL equal the reset values.

Verification
REQ-030 CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1; send 0x48:
  - Line shows 0 for 4 cycles, then bits 0,0,0,1,0,0,1,0 for 4 cycles each, then 1 for 4 cycles.
  - o_busy is high for 40 cycles; o_done pulses once.
REQ-031 Same word with PARITY=2 SHALL produce parity bit 0; with PARITY=1, parity bit 1. Frame length is 44 cycles.
REQ-032 STOP_BITS=2, send 0xFF SHALL give a start bit 0, eight 1 bits and 8 stop cycles, for a 44-cycle frame.
REQ-033 i_wr held high continuously with 0x55 then 0xAA SHALL produce two frames separated by exactly one idle cycle; the write presented mid-frame is ignored.
REQ-034 i_reset pulsed at cycle 10 of a 0x00 frame SHALL drive o_uart_tx=1, o_busy=0 and o_state=0 on the next cycle, with no o_done pulse.

Source files
------------

// File: rtl/uart_tx_if.sv
// Host-side handshake and line signals of the UART transmitter.
// The host drives i_wr/i_data and observes status; the transmitter owns the o_* signals.
interface uart_tx_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_wr;
   logic [DATA_BITS-1:0] i_data;
   logic                 o_busy;
   logic                 o_done;
   logic [2:0]           o_state;
   logic                 o_uart_tx;

   modport master (
      output i_wr, i_data,
      input  o_busy, o_done, o_state, o_uart_tx
   );

   modport slave (
      input  i_wr, i_data,
      output o_busy, o_done, o_state, o_uart_tx
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// One word is accepted when idle; writes while busy are dropped.
module uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic     i_clk,
   input  logic     i_reset,
   uart_tx_if.slave io_bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   localparam int               CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       LAST_DATA  = 4'(DATA_BITS - 1);
   localparam logic [3:0]       LAST_STOP  = 4'(STOP_BITS - 1);
   localparam logic             ODD_PARITY = (PARITY == 1);

   state_t               r_state, w_state_next;
   logic [CNT_W-1:0]     r_cnt, w_cnt_next;
   logic [3:0]           r_bit, w_bit_next;
   logic [DATA_BITS-1:0] r_shift, w_shift_next;
   logic                 r_parity, w_parity_next;
   logic                 r_done, w_done_next;
   logic                 r_tx, w_tx_next;
   logic                 w_tick;

   assign w_tick = (r_cnt == '0);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_done   <= 1'b0;
         r_tx     <= 1'b1;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_bit    <= w_bit_next;
         r_shift  <= w_shift_next;
         r_parity <= w_parity_next;
         r_done   <= w_done_next;
         r_tx     <= w_tx_next;
      end
   end

   // NOTE: every output of this block gets a default first so no latch can be inferred.
   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_bit_next    = r_bit;
      w_shift_next  = r_shift;
      w_parity_next = r_parity;
      w_done_next   = 1'b0;
      w_tx_next     = 1'b1;

      if (r_state != S_IDLE) begin
         w_cnt_next = w_tick ? CNT_RELOAD : r_cnt - CNT_W'(1);
      end

      case (r_state)
         S_IDLE: begin
            w_cnt_next = CNT_RELOAD;
            w_bit_next = '0;
            if (io_bus.i_wr) begin
               w_state_next  = S_START;
               w_shift_next  = io_bus.i_data;
               w_parity_next = (^io_bus.i_data) ^ ODD_PARITY;
            end
         end
         S_START: begin
            if (w_tick) w_state_next = S_DATA;
         end
         S_DATA: begin
            if (w_tick) begin
               w_shift_next = r_shift >> 1;
               if (r_bit == LAST_DATA) begin
                  w_bit_next   = '0;
                  w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  w_bit_next = r_bit + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (w_tick) w_state_next = S_STOP;
         end
         S_STOP: begin
            if (w_tick) begin
               if (r_bit == LAST_STOP) begin
                  w_bit_next   = '0;
                  w_state_next = S_IDLE;
                  w_done_next  = 1'b1;
               end else begin
                  w_bit_next = r_bit + 4'd1;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      // Line level is decided from the upcoming state so r_tx changes together with r_state.
      case (w_state_next)
         S_START:  w_tx_next = 1'b0;
         S_DATA:   w_tx_next = w_shift_next[0];
         S_PARITY: w_tx_next = w_parity_next;
         default:  w_tx_next = 1'b1;
      endcase
   end

   assign io_bus.o_busy    = (r_state != S_IDLE);
   assign io_bus.o_done    = r_done;
   assign io_bus.o_state   = r_state;
   assign io_bus.o_uart_tx = r_tx;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four instances cover no/even/odd parity and two stop bits.
// Each cycle of a frame is predicted as {line, busy, done, state} and compared on the falling edge.
module tb_uart_tx;

   localparam int CPB          = 4;
   localparam int PAR_MODE [4] = '{0, 2, 1, 0};
   localparam int STOPS    [4] = '{1, 1, 1, 2};

   typedef struct {
      int         k;
      int         cyc;
      logic [5:0] v;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       wr   [4];
   logic [7:0] din  [4];
   logic [5:0] obs  [4];
   exp_t       sb   [$];
   int         n_checks;
   int         n_errors;

   uart_tx_if #(.DATA_BITS(8)) bus0 ();
   uart_tx_if #(.DATA_BITS(8)) bus1 ();
   uart_tx_if #(.DATA_BITS(8)) bus2 ();
   uart_tx_if #(.DATA_BITS(8)) bus3 ();

   assign bus0.i_wr = wr[0];  assign bus0.i_data = din[0];
   assign bus1.i_wr = wr[1];  assign bus1.i_data = din[1];
   assign bus2.i_wr = wr[2];  assign bus2.i_data = din[2];
   assign bus3.i_wr = wr[3];  assign bus3.i_data = din[3];

   assign obs[0] = {bus0.o_uart_tx, bus0.o_busy, bus0.o_done, bus0.o_state};
   assign obs[1] = {bus1.o_uart_tx, bus1.o_busy, bus1.o_done, bus1.o_state};
   assign obs[2] = {bus2.o_uart_tx, bus2.o_busy, bus2.o_done, bus2.o_state};
   assign obs[3] = {bus3.o_uart_tx, bus3.o_busy, bus3.o_done, bus3.o_state};

   uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_MODE[0]), .STOP_BITS(STOPS[0]))
      dut0 (.i_clk(clk), .i_reset(rst), .io_bus(bus0));
   uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_MODE[1]), .STOP_BITS(STOPS[1]))
      dut1 (.i_clk(clk), .i_reset(rst), .io_bus(bus1));
   uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_MODE[2]), .STOP_BITS(STOPS[2]))
      dut2 (.i_clk(clk), .i_reset(rst), .io_bus(bus2));
   uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_MODE[3]), .STOP_BITS(STOPS[3]))
      dut3 (.i_clk(clk), .i_reset(rst), .io_bus(bus3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Predicts one frame cycle by cycle from the first cycle after acceptance.
   // A negative limit queues the whole frame plus its done cycle; otherwise only the first cycles.
   task automatic push_frame(input int k, input logic [7:0] d, input int limit);
      logic [5:0] seq [$];
      logic       p;
      exp_t       e;
      for (int c = 0; c < CPB; c++) seq.push_back({1'b0, 1'b1, 1'b0, 3'd1});
      for (int i = 0; i < 8; i++)
         for (int c = 0; c < CPB; c++) seq.push_back({d[i], 1'b1, 1'b0, 3'd2});
      if (PAR_MODE[k] != 0) begin
         p = ^d;
         if (PAR_MODE[k] == 1) p = ~p;
         for (int c = 0; c < CPB; c++) seq.push_back({p, 1'b1, 1'b0, 3'd3});
      end
      for (int s = 0; s < STOPS[k]; s++)
         for (int c = 0; c < CPB; c++) seq.push_back({1'b1, 1'b1, 1'b0, 3'd4});
      if (limit < 0) seq.push_back({1'b1, 1'b0, 1'b1, 3'd0});
      for (int i = 0; i < seq.size(); i++) begin
         if (limit >= 0 && i >= limit) break;
         e.k   = k;
         e.cyc = i + 1;
         e.v   = seq[i];
         sb.push_back(e);
      end
   endtask

   task automatic push_idle(input int k, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.k   = k;
         e.cyc = 100 + i;
         e.v   = {1'b1, 1'b0, 1'b0, 3'd0};
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   task automatic send(input int k, input logic [7:0] d);
      @(posedge clk);
      #1 wr[k] = 1'b1;
      din[k] = d;
      @(posedge clk);
      #1 wr[k] = 1'b0;
      push_frame(k, d, -1);
      drain();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check($sformatf("dut%0d_cyc%0d", e.k, e.cyc), 32'(obs[e.k]), 32'(e.v));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wr[k]  = 1'b0;
         din[k] = 8'h00;
      end
      // A write presented during reset must be ignored.
      wr[0]  = 1'b1;
      din[0] = 8'hA5;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) check($sformatf("in_reset%0d", k), 32'(obs[k]), 32'h20);
      wr[0] = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) check($sformatf("after_reset%0d", k), 32'(obs[k]), 32'h20);

      send(0, 8'h48);
      send(1, 8'h48);
      send(2, 8'h48);
      send(3, 8'hFF);
      for (int i = 0; i < 3; i++) send(0, 8'($urandom));

      // Write held high across two frames; the mid-frame data change must not disturb frame one.
      @(posedge clk);
      #1 wr[0] = 1'b1;
      din[0] = 8'h55;
      @(posedge clk);
      #1 push_frame(0, 8'h55, -1);
      push_frame(0, 8'hAA, -1);
      din[0] = 8'hAA;
      repeat (41) @(posedge clk);
      #1 wr[0] = 1'b0;
      drain();

      // Reset during cycle 10 of a frame aborts it with no done pulse.
      @(posedge clk);
      #1 wr[0] = 1'b1;
      din[0] = 8'h00;
      @(posedge clk);
      #1 wr[0] = 1'b0;
      push_frame(0, 8'h00, 10);
      push_idle(0, 3);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      wr[0] = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      wr[0] = 1'b0;
      drain();

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
